// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the byte-wide SPI master.
package spi_pkg;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;

    localparam int EDGE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK divider and edge counter: toggles sclk every CLKS_PER_HALF_BIT cycles
// while running and flags leading, trailing and final (16th) edges.
module spi_edge_gen
    import spi_pkg::*;
#(
    parameter logic CPOL              = 1'b0,
    parameter int   CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic sclk,
    output logic lead_pulse,
    output logic trail_pulse,
    output logic last_edge
);

    localparam int DIV_W = $clog2(CLKS_PER_HALF_BIT);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              tick;

    always_comb begin
        tick   = run && (div_q == DIV_W'(CLKS_PER_HALF_BIT - 1));
        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (clear) begin
            div_d  = '0;
            edge_d = '0;
            sclk_d = CPOL;
        end else if (tick) begin
            div_d  = '0;
            edge_d = edge_q + 1'b1;
            sclk_d = ~sclk_q;
        end else if (run) begin
            div_d  = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= CPOL;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    // The edge about to be produced is edge_q+1: odd numbers are leading.
    assign lead_pulse  = tick && !edge_q[0];
    assign trail_pulse = tick &&  edge_q[0];
    assign last_edge   = tick && (edge_q == EDGE_W'(15));
    assign sclk        = sclk_q;

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte SPI master: accepts a byte on the spitx handshake, shifts it
// out MSB-first on mosi while sampling miso, and returns the received byte.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = SPI_MODE0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spitx,
    input  logic       spitxdv,
    output logic       spitxready,
    output logic [7:0] spirx,
    output logic       spirxdv,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    spi_state_e state_q, state_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] spirx_q, spirx_d;
    logic       mosi_q, mosi_d;
    logic       accept, shift_en;
    logic       lead_pulse, trail_pulse, last_edge;
    logic       drive_pulse, sample_pulse;

    spi_edge_gen #(
        .CPOL              (CPOL),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_edge_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .run         (shift_en),
        .sclk        (sclk),
        .lead_pulse  (lead_pulse),
        .trail_pulse (trail_pulse),
        .last_edge   (last_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (spitxdv)   state_d = ST_SHIFT;
            ST_SHIFT: if (last_edge) state_d = ST_DONE;
            ST_DONE:  state_d = spitxdv ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spitxready = (state_q == ST_IDLE) || (state_q == ST_DONE);
        spirxdv    = (state_q == ST_DONE);
        shift_en   = (state_q == ST_SHIFT);
    end

    assign accept       = spitxdv && spitxready;
    assign drive_pulse  = CPHA ? lead_pulse  : trail_pulse;
    assign sample_pulse = CPHA ? trail_pulse : lead_pulse;

    // With CPHA=0 bit 7 goes out at accept, so the register is pre-shifted
    // and every later drive simply takes tx_sr_q[7].
    always_comb begin
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        spirx_d = spirx_q;
        mosi_d  = mosi_q;
        if (accept) begin
            rx_sr_d = '0;
            if (CPHA) begin
                tx_sr_d = spitx;
            end else begin
                mosi_d  = spitx[7];
                tx_sr_d = {spitx[6:0], 1'b0};
            end
        end else begin
            if (drive_pulse && !last_edge) begin
                mosi_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
            if (sample_pulse) rx_sr_d = {rx_sr_q[6:0], miso};
            if (last_edge)    spirx_d = rx_sr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            spirx_q <= '0;
            mosi_q  <= 1'b0;
        end else begin
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            spirx_q <= spirx_d;
            mosi_q  <= mosi_d;
        end
    end

    assign spirx = spirx_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: four instances (modes 0..3), one selected at a
// time, driven against an SPI slave model or a mosi->miso loopback.
module tb_spi_byte_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spitx;
    logic       spitxdv;
    logic       miso;

    logic [3:0] ready_w, rxdv_w, sclk_w, mosi_w;
    logic [7:0] rx_w [4];

    logic [1:0] sel;
    logic       loop_en;
    logic       s_ready, s_rxdv, s_sclk, s_mosi, s_cpol, s_cpha;
    logic [7:0] s_rx;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_byte_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u_m0 (
        .clk(clk), .rst(rst), .spitx(spitx), .spitxdv(spitxdv), .spitxready(ready_w[0]),
        .spirx(rx_w[0]), .spirxdv(rxdv_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso));
    spi_byte_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2)) u_m1 (
        .clk(clk), .rst(rst), .spitx(spitx), .spitxdv(spitxdv), .spitxready(ready_w[1]),
        .spirx(rx_w[1]), .spirxdv(rxdv_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso));
    spi_byte_master #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(2)) u_m2 (
        .clk(clk), .rst(rst), .spitx(spitx), .spitxdv(spitxdv), .spitxready(ready_w[2]),
        .spirx(rx_w[2]), .spirxdv(rxdv_w[2]), .sclk(sclk_w[2]), .mosi(mosi_w[2]), .miso(miso));
    spi_byte_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) u_m3 (
        .clk(clk), .rst(rst), .spitx(spitx), .spitxdv(spitxdv), .spitxready(ready_w[3]),
        .spirx(rx_w[3]), .spirxdv(rxdv_w[3]), .sclk(sclk_w[3]), .mosi(mosi_w[3]), .miso(miso));

    assign s_ready = ready_w[sel];
    assign s_rxdv  = rxdv_w[sel];
    assign s_sclk  = sclk_w[sel];
    assign s_mosi  = mosi_w[sel];
    assign s_rx    = rx_w[sel];
    assign s_cpol  = sel[1];
    assign s_cpha  = sel[0];

    // Slave model: looks at sclk/mosi on the falling clk edge, when they are settled.
    logic       sclk_prev = 1'b0, mosi_prev = 1'b0;
    logic [7:0] slv_reply = 8'h00, slv_sr = 8'h00, slv_rx = 8'h00, slv_got = 8'h00;
    logic       slv_miso = 1'b0;
    int         edge_cnt = 0, mosi_viol = 0;
    logic       sclk_evt, samp_evt, slv_load;

    assign sclk_evt = (s_sclk != sclk_prev);
    assign samp_evt = ((sclk_prev == s_cpol) != s_cpha);
    assign slv_load = s_ready && spitxdv && !rst;
    assign miso     = loop_en ? s_mosi : slv_miso;

    always @(negedge clk) begin
        sclk_prev <= s_sclk;
        mosi_prev <= s_mosi;
        if (sclk_evt) begin
            edge_cnt <= edge_cnt + 1;
            if (samp_evt) begin
                slv_rx <= {slv_rx[6:0], s_mosi};
                if (s_mosi != mosi_prev) mosi_viol <= mosi_viol + 1;
            end else begin
                slv_miso <= s_cpha ? slv_sr[7] : slv_sr[6];
                slv_sr   <= {slv_sr[6:0], 1'b0};
            end
            if (edge_cnt == 15) slv_got <= samp_evt ? {slv_rx[6:0], s_mosi} : slv_rx;
        end
        if (slv_load) begin
            slv_sr    <= slv_reply;
            slv_rx    <= 8'h00;
            edge_cnt  <= 0;
            mosi_viol <= 0;
            if (!s_cpha) slv_miso <= slv_reply[7];
        end
    end

    typedef struct {
        logic [1:0] sel;
        logic       loop;
        logic [7:0] tx;
        logic [7:0] reply;
        logic [7:0] exp_rx;
        logic [7:0] exp_slv;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic select_dut(input logic [1:0] m, input logic lp);
        sel     = m;
        loop_en = lp;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!s_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output int lat);
        wait_ready();
        spitx   = tx;
        spitxdv = 1'b1;
        @(posedge clk); #1;
        spitxdv = 1'b0;
        lat     = 1;
        while (!s_rxdv && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        rx = s_rx;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        int         lat;
        select_dut(v.sel, v.loop);
        slv_reply = v.reply;
        xfer(v.tx, rx, lat);
        chk("latency", lat, v.lat);
        chk("spirx", rx, v.exp_rx);
        chk("ready_in_done", s_ready, 1);
        @(negedge clk); #1;
        chk("slave_rx", slv_got, v.exp_slv);
        chk("sclk_edges", edge_cnt, 16);
        chk("sclk_idle", s_sclk, v.sel[1]);
        chk("mosi_stable_at_sample", mosi_viol, 0);
        @(posedge clk); #1;
        chk("rxdv_one_cycle", s_rxdv, 0);
        chk("spirx_held", s_rx, v.exp_rx);
    endtask

    // Command-processor style: next byte offered as soon as spitxready rises.
    task automatic b2b(input logic [1:0] m);
        logic [7:0] bytes [3];
        int         t_prev = 0;
        bytes[0] = 8'h80;
        bytes[1] = 8'h05;
        bytes[2] = 8'h00;
        select_dut(m, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            if (i > 0) begin
                chk("b2b_rxdv", s_rxdv, 1);
                chk("b2b_rx", s_rx, bytes[i-1]);
                chk("b2b_gap", cyc - t_prev, 33);
            end
            if (i < 3) begin
                spitx   = bytes[i];
                spitxdv = 1'b1;
                t_prev  = cyc;
                @(posedge clk); #1;
                spitxdv = 1'b0;
            end
        end
    endtask

    task automatic busy_test();
        int         t0, t1, busy_acc, guard;
        logic [7:0] g1;
        select_dut(2'd0, 1'b0);
        slv_reply = 8'h21;
        wait_ready();
        spitx   = 8'h12;
        spitxdv = 1'b1;
        t0      = cyc;
        @(posedge clk); #1;
        spitxdv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        spitx    = 8'hFF;
        spitxdv  = 1'b1;
        busy_acc = 0;
        repeat (10) begin
            if (s_ready) busy_acc++;
            @(posedge clk); #1;
        end
        spitxdv = 1'b0;
        chk("busy_ready_low", busy_acc, 0);
        while (cyc - t0 < 30) begin
            @(posedge clk); #1;
        end
        slv_reply = 8'h44;
        spitxdv   = 1'b1;
        wait_ready();
        chk("busy_accept_at_done", cyc - t0, 33);
        chk("busy_first_rxdv", s_rxdv, 1);
        chk("busy_first_rx", s_rx, 8'h21);
        t1 = cyc;
        @(negedge clk); #1;
        g1 = slv_got;
        chk("busy_slave_first", g1, 8'h12);
        @(posedge clk); #1;
        spitxdv = 1'b0;
        guard   = 0;
        while (!s_rxdv && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("busy_second_gap", cyc - t1, 33);
        chk("busy_second_rx", s_rx, 8'h44);
        @(negedge clk); #1;
        chk("busy_slave_second", slv_got, 8'hFF);
    endtask

    task automatic reset_test();
        int         t0, rxdv_seen;
        logic [7:0] rx;
        int         lat;
        select_dut(2'd2, 1'b1);
        wait_ready();
        spitx   = 8'hFF;
        spitxdv = 1'b1;
        t0      = cyc;
        @(posedge clk); #1;
        spitxdv = 1'b0;
        while (cyc - t0 < 15) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_sclk", s_sclk, 0);
        chk("pre_rst_mosi", s_mosi, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_sclk", s_sclk, 1);
        chk("rst_mosi", s_mosi, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_spirx", s_rx, 0);
        rxdv_seen = 0;
        repeat (40) begin
            if (s_rxdv) rxdv_seen++;
            @(posedge clk); #1;
        end
        chk("rst_no_rxdv", rxdv_seen, 0);
        xfer(8'h5A, rx, lat);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_rx", rx, 8'h5A);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        spitx   = 8'h00;
        spitxdv = 1'b0;
        sel     = 2'd0;
        loop_en = 1'b0;

        vecs[0] = '{sel: 2'd0, loop: 1'b1, tx: 8'hA5, reply: 8'h00, exp_rx: 8'hA5, exp_slv: 8'hA5, lat: 33};
        vecs[1] = '{sel: 2'd3, loop: 1'b0, tx: 8'hC3, reply: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'hC3, lat: 65};
        vecs[2] = '{sel: 2'd1, loop: 1'b0, tx: 8'h96, reply: 8'h69, exp_rx: 8'h69, exp_slv: 8'h96, lat: 33};
        vecs[3] = '{sel: 2'd2, loop: 1'b0, tx: 8'h0F, reply: 8'hF0, exp_rx: 8'hF0, exp_slv: 8'h0F, lat: 33};
        vecs[4] = '{sel: 2'd0, loop: 1'b0, tx: 8'h00, reply: 8'hFF, exp_rx: 8'hFF, exp_slv: 8'h00, lat: 33};
        vecs[5] = '{sel: 2'd3, loop: 1'b0, tx: 8'hFF, reply: 8'h01, exp_rx: 8'h01, exp_slv: 8'hFF, lat: 65};

        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            sel = 2'(m);
            #1;
            chk("reset_ready", s_ready, 1);
            chk("reset_rxdv", s_rxdv, 0);
            chk("reset_spirx", s_rx, 0);
            chk("reset_sclk", s_sclk, m / 2);
            chk("reset_mosi", s_mosi, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        b2b(2'd0);
        b2b(2'd1);
        busy_test();
        reset_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-wide SPI master that executes the single-byte transfers requested by the command processor over its `spitx`/`spitxdv`/`spitxready`/`spirx`/`spirxdv` handshake. It generates SCLK, shifts MOSI out MSB-first, samples MISO, and returns the received byte with a one-cycle valid pulse. Chip select stays with the command processor (`spicsadc`), so multi-byte ADC register accesses are sequences of independent byte transfers on this block.

## Interface
Parameters:
- `SPI_MODE`, default 0: SPI mode 0–3. CPOL = bit 1, CPHA = bit 0.
- `CLKS_PER_HALF_BIT`, default 2: `clk` cycles per SCLK half-period. Legal values are 2 or greater.

Ports:
- `clk` in 1: the single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `spitx` in 8: byte to transmit. Sampled only on the accept cycle.
- `spitxdv` in 1: transmit request. A request is accepted when `spitxdv && spitxready`.
- `spitxready` out 1: high when idle and able to accept a request.
- `spirx` out 8: received byte. Valid while `spirxdv` is high, and held until the next transfer completes.
- `spirxdv` out 1: one-cycle pulse when the received byte is valid.
- `sclk` out 1: SPI clock.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- Reset values:
  - `spitxready` = 1
  - `spirxdv` = 0
  - `spirx` = 0
  - `sclk` = CPOL
  - `mosi` = 0
  - all counters and the shift register = 0
  - state = IDLE
- States and transitions:
  - IDLE: `spitxready` = 1. On accept, load `spitx` into the TX shift register, clear the edge counter to 0 and the divider to 0, and go to SHIFT. If CPHA = 0, `mosi` takes bit 7 in the accept cycle's next-state.
  - SHIFT: the divider counts 0..`CLKS_PER_HALF_BIT`-1. On terminal count, `sclk` toggles and the edge counter increments (1..16). Odd edges are leading, even edges are trailing.
    - CPHA = 0: sample `miso` on leading edges. Drive the next bit on trailing edges 2, 4, …, 14.
    - CPHA = 1: drive the next bit on leading edges, starting with bit 7 at edge 1. Sample `miso` on trailing edges.
    - Sampled bits shift into the RX register LSB-in, so the first bit sampled ends up as bit 7.
    - After edge 16, go to DONE.
  - DONE, one cycle: `spirx` <= RX register, `spirxdv` = 1, `spitxready` = 1, then return to IDLE. `sclk` already equals CPOL because it toggled an even number of times.
- `mosi` holds its last driven bit after the transfer, until the next accept.
- `spitxdv` while busy is ignored. It is not queued, and `spitx` is not re-sampled.
- `spitxdv` in the DONE cycle is accepted, because `spitxready` = 1 there. The next transfer therefore starts with no idle cycle in between.
- Reset asserted mid-transfer: next cycle all outputs take their reset values, no `spirxdv` pulse is produced, and the partial byte is discarded.

## Timing
- Let T be the accept cycle and H = `CLKS_PER_HALF_BIT`.
- `spitxready` falls at T+1.
- SCLK edge k (k = 1..16) appears on `sclk` at T+k·H.
- `spirxdv` and `spitxready` go high at T+16H+1.
- Busy time is 16H+1 cycles. The earliest next accept is at T+16H+1.
- `miso` is sampled in the cycle that registers the sampling edge, i.e. ahead of the register update.
- `mosi` setup before the sampling edge is at least H cycles.
- `spirxdv` is high for exactly 1 cycle.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_MODE0`..`SPI_MODE3` constants
  - the state encoding (IDLE, SHIFT, DONE)
  - the edge-count width constant (5 bits)
- One natural sub-module: `spi_edge_gen`, the divider plus edge counter. It outputs `sclk`, `lead_pulse`, `trail_pulse` and `last_edge`, and is cleared on accept and on `rst`. The top level holds the FSM, the shift registers and the handshake.

## Test plan
- Mode 0, H=2, `miso` looped to `mosi`, send 0xA5 at T.
  - Required: `spirx` = 0xA5 with `spirxdv` at T+33.
  - Required: exactly 16 `sclk` edges, with `sclk` idling low.
- Mode 3, H=4, slave model returns 0x3C while receiving 0xC3.
  - Required: slave captures 0xC3 and `spirx` = 0x3C at T+65.
  - Required: `sclk` idles high, and `mosi` is stable across every rising edge.
- Command-processor sequence, modes 0 and 1: three bytes 0x80, 0x05, 0x00, with `spitxdv` pulsed once per byte after `spitxready`.
  - Required: three `spirxdv` pulses with correct bytes.
  - Required: a back-to-back accept in the DONE cycle produces no missed edge.
- `spitxdv` held high for 10 cycles mid-transfer with `spitx` = 0xFF after accepting 0x12.
  - Required: the slave receives only 0x12.
  - Required: the next transfer starts only at the DONE cycle, and then sends 0xFF.
- `rst` pulsed at edge 7 of a mode-2 transfer.
  - Required: next cycle `sclk` = 1, `mosi` = 0, `spitxready` = 1.
  - Required: no `spirxdv` pulse.
  - Required: a following 0x5A transfer completes correctly.
